// File: rtl/data_mem_responder.sv
// Responder for the core's data-memory port: one load/store at a time, RISC-V B/H/W sizing,
// fixed wait-state latency, backed by a little-endian byte array.
module data_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         MEM_BYTES = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // Rejection rules; a request with neither wr nor rd is a no-op and never errors.
  function automatic logic req_err_f(input logic w, input logic r, input logic [2:0] f3,
                                     input logic [ADDR_W-1:0] a);
    logic bad_v;
    case (f3)
      3'b000:  bad_v = 1'b0;
      3'b001:  bad_v = a[0];
      3'b010:  bad_v = (a[1:0] != 2'b00);
      3'b100:  bad_v = w;
      3'b101:  bad_v = a[0];
      default: bad_v = 1'b1;
    endcase
    return (w & r) | ((w | r) & bad_v);
  endfunction

  function automatic logic [DATA_W-1:0] extend_f(input logic [2:0] f3, input logic [DATA_W-1:0] raw);
    logic [DATA_W-1:0] res_v;
    case (f3[1:0])
      2'b00:   res_v = f3[2] ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
      2'b01:   res_v = f3[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      2'b10:   res_v = raw;
      default: res_v = {DATA_W{1'b0}};
    endcase
    return res_v;
  endfunction

  function automatic logic [3:0] byte_en_f(input logic [2:0] f3);
    logic [3:0] be_v;
    case (f3[1:0])
      2'b00:   be_v = 4'b0001;
      2'b01:   be_v = 4'b0011;
      2'b10:   be_v = 4'b1111;
      default: be_v = 4'b0000;
    endcase
    return be_v;
  endfunction

  state_t              state_r, state_s;
  logic [3:0]          cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [2:0]          funct3_r;
  logic                wr_r, rd_r, err_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                req_ready_r, rsp_valid_r, rsp_err_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic                accept_s, enter_resp_s, mem_we_s;
  logic [ADDR_W-1:0]   baddr_s [4];
  logic [DATA_W-1:0]   raw_s;
  logic [3:0]          be_s;
  logic [7:0]          mem_r [MEM_BYTES];

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rd_data   = rd_data_r;
  assign rsp_err   = rsp_err_r;

  // Handshake qualifiers, byte lanes of the latched request and raw little-endian read word.
  always_comb begin
    accept_s     = req_valid & req_ready_r & (state_r == ST_IDLE);
    enter_resp_s = (state_s == ST_RESP);
    mem_we_s     = enter_resp_s & wr_r & ~err_r;
    be_s         = byte_en_f(funct3_r);
    for (int i = 0; i < 4; i++) begin
      baddr_s[i] = addr_r + ADDR_W'(i);
    end
    raw_s = {mem_r[baddr_s[3]], mem_r[baddr_s[2]], mem_r[baddr_s[1]], mem_r[baddr_s[0]]};
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and wait-state counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        cnt_r <= WAIT_LOAD;
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Request capture at accept; fields are not looked at again on the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r   <= {ADDR_W{1'b0}};
      funct3_r <= 3'd0;
      wr_r     <= 1'b0;
      rd_r     <= 1'b0;
      err_r    <= 1'b0;
      wdata_r  <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      addr_r   <= addr;
      funct3_r <= funct3;
      wr_r     <= wr;
      rd_r     <= rd;
      err_r    <= req_err_f(wr, rd, funct3, addr);
      wdata_r  <= wr_data;
    end
  end

  // Registered response outputs; rd_data holds until the next response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rd_data_r   <= {DATA_W{1'b0}};
    end else begin
      req_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= enter_resp_s;
      rsp_err_r   <= enter_resp_s & err_r;
      if (enter_resp_s) begin
        rd_data_r <= (rd_r & ~wr_r & ~err_r) ? extend_f(funct3_r, raw_s) : {DATA_W{1'b0}};
      end
    end
  end

  // Byte array commit; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_s && be_s[i]) begin
        mem_r[baddr_s[i]] <= wdata_r[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random traffic
// checked against a byte-array reference model.
module tb_data_mem_responder;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, wr, rd;
  logic [8:0]  addr;
  logic [2:0]  funct3;
  logic [31:0] wr_data;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rd_data;

  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  logic [7:0] ref_mem [512];

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .wr(wr), .rd(rd), .addr(addr), .funct3(funct3), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rd_data(rd_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Reference: decide rejection from the rules, then touch the byte array.
  function automatic void model(input logic w, input logic r, input logic [2:0] f3,
                                input logic [8:0] a, input logic [31:0] d,
                                output logic [31:0] edata, output logic eerr);
    int          nb;
    logic [31:0] v;
    logic        bad;
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (w && (f3 == 3'd4)) ||
          (((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'd0));
    eerr  = (w && r) || ((w || r) && bad);
    edata = 32'd0;
    if (!eerr && w) begin
      for (int i = 0; i < nb; i++) ref_mem[a + 9'(i)] = d[8*i +: 8];
    end else if (!eerr && r) begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a + 9'(i)]) << (8 * i));
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      edata = v;
    end
  endfunction

  // One request from a negedge: accept, latency, response contents, pulse width.
  task automatic xact(input logic w, input logic r, input logic [2:0] f3, input logic [8:0] a,
                      input logic [31:0] d, output logic [31:0] obs_data, output logic obs_err);
    int          n;
    logic [31:0] ed;
    logic        ee;
    req_valid = 1'b1; wr = w; rd = r; funct3 = f3; addr = a; wr_data = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk1("accept_bound", (n < 50), 1'b1);
    model(w, r, f3, a, d, ed, ee);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; wr = 1'($urandom); rd = 1'($urandom); addr = 9'($urandom);
    funct3 = 3'($urandom); wr_data = $urandom;
    chk1("ready_low_busy", req_ready, 1'b0);
    n = 1;
    while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("latency", 32'(n), 32'(WAIT + 1));
    chk1("rsp_err", rsp_err, ee);
    chk("rd_data", rd_data, ed);
    obs_data = rd_data;
    obs_err  = rsp_err;
    @(negedge clk);
    chk1("rsp_width", rsp_valid, 1'b0);
    chk("rd_data_hold", rd_data, ed);
  endtask

  initial begin
    logic [31:0] od, exp_w;
    logic        oe, seen;
    int          acc, rsp, k;
    logic        w, r;
    logic [2:0]  f;
    logic [8:0]  a;

    reset = 1'b0; req_valid = 1'b0; wr = 1'b0; rd = 1'b0;
    addr = 9'd0; funct3 = 3'd0; wr_data = 32'd0;
    #1;
    chk1("rst_ready", req_ready, 1'b0);
    chk1("rst_valid", rsp_valid, 1'b0);
    chk1("rst_err", rsp_err, 1'b0);
    chk("rst_rd_data", rd_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk1("ready_after_rst", req_ready, 1'b1);

    // Known contents everywhere before any load.
    for (int i = 0; i < 128; i++) xact(1'b1, 1'b0, 3'b010, 9'(i * 4), $urandom, od, oe);

    xact(1'b1, 1'b0, 3'b010, 9'h010, 32'hDEADBEEF, od, oe);
    chk1("t1_sw_err", oe, 1'b0);
    xact(1'b0, 1'b1, 3'b010, 9'h010, 32'd0, od, oe);
    chk("t1_lw", od, 32'hDEADBEEF);

    xact(1'b0, 1'b1, 3'b000, 9'h013, 32'd0, od, oe); chk("t2_lb", od, 32'hFFFFFFDE);
    xact(1'b0, 1'b1, 3'b100, 9'h013, 32'd0, od, oe); chk("t2_lbu", od, 32'h000000DE);
    xact(1'b0, 1'b1, 3'b001, 9'h012, 32'd0, od, oe); chk("t2_lh", od, 32'hFFFFDEAD);
    xact(1'b0, 1'b1, 3'b101, 9'h012, 32'd0, od, oe); chk("t2_lhu", od, 32'h0000DEAD);

    xact(1'b1, 1'b0, 3'b000, 9'h011, 32'h12345655, od, oe);
    xact(1'b0, 1'b1, 3'b010, 9'h010, 32'd0, od, oe); chk("t3_sb_lw", od, 32'hDEAD55EF);
    xact(1'b1, 1'b0, 3'b001, 9'h1FE, 32'h0000AAAA, od, oe);
    xact(1'b0, 1'b1, 3'b010, 9'h1FC, 32'd0, od, oe); chk("t3_top_half", {16'd0, od[31:16]}, 32'h0000AAAA);

    xact(1'b0, 1'b1, 3'b001, 9'h011, 32'd0, od, oe);
    chk1("t4_lh_mis_err", oe, 1'b1); chk("t4_lh_mis_data", od, 32'd0);
    xact(1'b1, 1'b0, 3'b010, 9'h012, 32'hFFFFFFFF, od, oe); chk1("t4_sw_mis_err", oe, 1'b1);
    xact(1'b0, 1'b1, 3'b010, 9'h010, 32'd0, od, oe); chk("t4_unchanged", od, 32'hDEAD55EF);
    xact(1'b0, 1'b1, 3'b011, 9'h010, 32'd0, od, oe); chk1("t4_f3_011_err", oe, 1'b1);
    xact(1'b1, 1'b1, 3'b010, 9'h010, 32'd0, od, oe); chk1("t4_wr_rd_err", oe, 1'b1);
    xact(1'b0, 1'b0, 3'b010, 9'h010, 32'd0, od, oe); chk1("t4_nop_err", oe, 1'b0);

    // req_valid held high: one accept every WAIT+2 cycles, one response per accept.
    model(1'b0, 1'b1, 3'b010, 9'h010, 32'd0, exp_w, oe);
    req_valid = 1'b1; wr = 1'b0; rd = 1'b1; funct3 = 3'b010; addr = 9'h010;
    acc = 0; rsp = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) acc++;
      if (rsp_valid) begin rsp++; chk("t5_data", rd_data, exp_w); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) rsp++;
      @(negedge clk);
    end
    chk("t5_accepts", 32'(acc), 32'(20 / (WAIT + 2)));
    chk("t5_responses", 32'(rsp), 32'(acc));

    // Reset during WAIT of a store drops it.
    req_valid = 1'b1; wr = 1'b1; rd = 1'b0; funct3 = 3'b010; addr = 9'h010; wr_data = 32'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk1("t6_valid", rsp_valid, 1'b0);
    chk1("t6_ready", req_ready, 1'b0);
    chk("t6_rd_data", rd_data, 32'd0);
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | rsp_valid; end
    reset = 1'b1;
    repeat (5) begin @(negedge clk); seen = seen | rsp_valid; end
    chk1("t6_no_rsp", seen, 1'b0);
    xact(1'b0, 1'b1, 3'b010, 9'h010, 32'd0, od, oe); chk("t6_prior", od, 32'hDEAD55EF);

    // Random traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 7);
      a = 9'($urandom);
      f = 3'($urandom);
      case (k)
        0:         begin w = 1'b0; r = 1'b0; f = 3'b010; a[1:0] = 2'b00; end
        1:         begin w = 1'b1; r = 1'b1; end
        2, 3, 4:   begin w = 1'b1; r = 1'b0; end
        default:   begin w = 1'b0; r = 1'b1; end
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (f[1:0] == 2'd1) a[0] = 1'b0;
        else if (f[1:0] == 2'd2) a[1:0] = 2'd0;
      end
      xact(w, r, f, a, $urandom, od, oe);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
